// File: rtl/afe_pkg.sv
// afe_pkg: shared types and constants for the AFE SPI result reader.
//
// Contents:
//   afe_state_e      - sequencing FSM states of afe_spi_reader
//   AFE_REG_*        - AFE register addresses (control, LED2/LED1 results)
//   AFE_SPI_READ     - control word that switches the AFE into register-read mode
//   FRAME_BITS       - SCLK periods per SPI frame
//   afe_fmt_channel  - per-channel result formatting
//
// Build option: define AFE_SPI_SIGN_EXT_EN to sign-extend each 24-bit channel
// from bit 21, matching the AFE's 22-bit two's-complement result format.
// When it is undefined, the captured 24 bits are passed through unchanged.

package afe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CTRL,
        ST_GAP0,
        ST_RD0,
        ST_GAP1,
        ST_RD1,
        ST_DONE
    } afe_state_e;

    localparam logic [7:0]  AFE_REG_CTRL0   = 8'h00;
    localparam logic [7:0]  AFE_REG_LED2VAL = 8'h2A;
    localparam logic [7:0]  AFE_REG_LED1VAL = 8'h2C;
    localparam logic [23:0] AFE_SPI_READ    = 24'h000001;
    localparam int unsigned FRAME_BITS      = 32;

    function automatic logic [23:0] afe_fmt_channel(input logic [23:0] raw);
`ifdef AFE_SPI_SIGN_EXT_EN
        // The AFE result is 22-bit two's complement; bits [23:22] follow bit 21.
        return {{2{raw[21]}}, raw[21:0]};
`else
        return raw;
`endif
    endfunction

endpackage

// File: rtl/afe_spi_shifter.sv
// afe_spi_shifter: one 32-bit SPI mode-0 frame engine (MSB first).
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   go_i         - one-cycle start; ignored while a frame is in flight
//   tx_word_i    - 32-bit word to shift out, sampled on go_i
//   somi_i       - serial data from the slave, sampled on SCLK rising edges
//   rx_word_o    - last 24 bits received (frame cycles 9..32)
//   done_o       - high in the final clk cycle of the frame (SCLK drops on the
//                  following edge), so the caller can raise chip-select on the
//                  same edge as the last falling SCLK edge
//   sclk_o       - SPI clock, idles low, CLK_DIV clk cycles per half period
//   simo_o       - serial data to the slave, updated on SCLK falling edges
//
// Chip-select is not handled here; the caller owns it.

module afe_spi_shifter
    import afe_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go_i,
    input  logic [31:0] tx_word_i,
    input  logic        somi_i,
    output logic [23:0] rx_word_o,
    output logic        done_o,
    output logic        sclk_o,
    output logic        simo_o
);

    logic        active_q;
    logic        sclk_q;
    logic        simo_q;
    logic [7:0]  cnt_q;
    logic [4:0]  bit_q;
    logic [30:0] tx_q;      // bits still to send after the one on simo_q
    logic [23:0] rx_q;      // only the trailing 24 bits carry register data

    logic phase_end;
    assign phase_end = (cnt_q == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            simo_q   <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else if (!active_q) begin
            if (go_i) begin
                // First bit goes out now, a full low phase before the first rise.
                active_q <= 1'b1;
                sclk_q   <= 1'b0;
                simo_q   <= tx_word_i[31];
                tx_q     <= tx_word_i[30:0];
                cnt_q    <= '0;
                bit_q    <= '0;
            end
        end else if (phase_end) begin
            cnt_q <= '0;
            if (!sclk_q) begin
                sclk_q <= 1'b1;
                rx_q   <= {rx_q[22:0], somi_i};
            end else begin
                sclk_q <= 1'b0;
                if (bit_q == 5'(FRAME_BITS - 1)) begin
                    active_q <= 1'b0;
                    simo_q   <= 1'b0;
                end else begin
                    bit_q  <= bit_q + 5'd1;
                    simo_q <= tx_q[30];
                    tx_q   <= {tx_q[29:0], 1'b0};
                end
            end
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign done_o    = active_q && sclk_q && phase_end && (bit_q == 5'(FRAME_BITS - 1));
    assign rx_word_o = rx_q;
    assign sclk_o    = sclk_q;
    assign simo_o    = simo_q;

endmodule

// File: rtl/afe_spi_reader.sv
// afe_spi_reader: on each AFE ADC_RDY edge, reads the two 24-bit result
// registers over SPI and presents them as one 48-bit word with a ready pulse.
//
// Ports:
//   clk, rst_n  - 50 MHz clock, asynchronous active-low reset
//   start       - level enable; new transactions begin only while high
//   adc_rdy     - AFE ADC_RDY, asynchronous, synchronised internally
//   spi_sclk    - SPI clock (mode 0, idles low)
//   spi_ste     - SPI chip select, active low
//   spi_simo    - master out, MSB first
//   spi_somi    - master in
//   data_out    - {ch1[23:0], ch0[23:0]}, held until the next transaction
//   data_rdy    - one-clk pulse when data_out updates
//   busy        - high from the accepted edge until data_rdy
//   overrun     - one-clk pulse when an adc_rdy edge is dropped
//
// Sequence: control write (SPI_READ), gap, read ADDR_CH0, gap, read ADDR_CH1.
// Build option: AFE_SPI_SIGN_EXT_EN sign-extends each channel from bit 21.

module afe_spi_reader
    import afe_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 8,
    parameter logic [7:0]  ADDR_CH0 = AFE_REG_LED2VAL,
    parameter logic [7:0]  ADDR_CH1 = AFE_REG_LED1VAL,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        adc_rdy,
    output logic        spi_sclk,
    output logic        spi_ste,
    output logic        spi_simo,
    input  logic        spi_somi,
    output logic [47:0] data_out,
    output logic        data_rdy,
    output logic        busy,
    output logic        overrun
);

    afe_state_e  state_q;
    logic [1:0]  sync_q;
    logic        sync_prev_q;
    logic [7:0]  gap_q;
    logic        go_q;
    logic        ste_q;
    logic [23:0] ch0_q;
    logic [23:0] ch1_q;
    logic [47:0] data_q;
    logic        rdy_q;
    logic        busy_q;
    logic        ovr_q;

    logic [31:0] tx_word_d;
    logic [23:0] sh_rx;
    logic        sh_done;
    logic        rdy_rise;

    assign rdy_rise = sync_q[1] & ~sync_prev_q;

    // go_q is high in the first cycle of a frame state, so the word is
    // selected from the state the shifter is about to serve.
    always_comb begin
        tx_word_d = '0;
        case (state_q)
            ST_WR_CTRL: tx_word_d = {AFE_REG_CTRL0, AFE_SPI_READ};
            ST_RD0:     tx_word_d = {ADDR_CH0, 24'h000000};
            ST_RD1:     tx_word_d = {ADDR_CH1, 24'h000000};
            default:    tx_word_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Synchroniser resets high so a level already high at release
            // cannot look like a fresh edge.
            sync_q      <= 2'b11;
            sync_prev_q <= 1'b1;
            state_q     <= ST_IDLE;
            gap_q       <= '0;
            go_q        <= 1'b0;
            ste_q       <= 1'b1;
            ch0_q       <= '0;
            ch1_q       <= '0;
            data_q      <= '0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], adc_rdy};
            sync_prev_q <= sync_q[1];
            go_q        <= 1'b0;
            rdy_q       <= 1'b0;
            // busy_q is still high in DONE, so an edge landing there is dropped.
            ovr_q       <= rdy_rise & busy_q;

            case (state_q)
                ST_IDLE: begin
                    if (rdy_rise && start) begin
                        state_q <= ST_WR_CTRL;
                        busy_q  <= 1'b1;
                        ste_q   <= 1'b0;
                        go_q    <= 1'b1;
                    end
                end
                ST_WR_CTRL: begin
                    if (sh_done) begin
                        ste_q   <= 1'b1;
                        gap_q   <= '0;
                        state_q <= ST_GAP0;
                    end
                end
                ST_GAP0: begin
                    if (gap_q == 8'(CS_GAP - 1)) begin
                        ste_q   <= 1'b0;
                        go_q    <= 1'b1;
                        state_q <= ST_RD0;
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                ST_RD0: begin
                    if (sh_done) begin
                        ch0_q   <= sh_rx;
                        ste_q   <= 1'b1;
                        gap_q   <= '0;
                        state_q <= ST_GAP1;
                    end
                end
                ST_GAP1: begin
                    if (gap_q == 8'(CS_GAP - 1)) begin
                        ste_q   <= 1'b0;
                        go_q    <= 1'b1;
                        state_q <= ST_RD1;
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                ST_RD1: begin
                    if (sh_done) begin
                        ch1_q   <= sh_rx;
                        ste_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    data_q  <= {afe_fmt_channel(ch1_q), afe_fmt_channel(ch0_q)};
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    afe_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .go_i      (go_q),
        .tx_word_i (tx_word_d),
        .somi_i    (spi_somi),
        .rx_word_o (sh_rx),
        .done_o    (sh_done),
        .sclk_o    (spi_sclk),
        .simo_o    (spi_simo)
    );

    assign spi_ste  = ste_q;
    assign data_out = data_q;
    assign data_rdy = rdy_q;
    assign busy     = busy_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_afe_spi_reader.sv
// Testbench for afe_spi_reader with an AFE SPI slave model and scoreboard.

module tb_afe_spi_reader;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned CS_GAP  = 4;
    localparam logic [7:0]  A0      = 8'h2A;
    localparam logic [7:0]  A1      = 8'h2C;
    localparam int          LAT     = 3 * 64 * CLK_DIV + 2 * CS_GAP + 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        adc_rdy;
    logic        spi_sclk;
    logic        spi_ste;
    logic        spi_simo;
    logic        spi_somi = 1'b0;
    logic [47:0] data_out;
    logic        data_rdy;
    logic        busy;
    logic        overrun;

    afe_spi_reader #(
        .CLK_DIV  (CLK_DIV),
        .ADDR_CH0 (A0),
        .ADDR_CH1 (A1),
        .CS_GAP   (CS_GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .adc_rdy  (adc_rdy),
        .spi_sclk (spi_sclk),
        .spi_ste  (spi_ste),
        .spi_simo (spi_simo),
        .spi_somi (spi_somi),
        .data_out (data_out),
        .data_rdy (data_rdy),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [31:0] exp_frames[$];
    logic [47:0] exp_data[$];
    logic [23:0] slave_ch0 = 24'h123456;
    logic [23:0] slave_ch1 = 24'hABCDEF;
    int rdy_cnt = 0;
    int ovr_cnt = 0;
    int frame_cnt = 0;
    int ste_fall_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag, input string why);
        n_cmp++;
        n_err++;
        $error("FAIL %s: %s", tag, why);
    endtask

    function automatic logic [23:0] fmt(input logic [23:0] raw);
`ifdef AFE_SPI_SIGN_EXT_EN
        return {{2{raw[21]}}, raw[21:0]};
`else
        return raw;
`endif
    endfunction

    function automatic logic [23:0] lookup(input logic [7:0] addr);
        if (addr == A0) return slave_ch0;
        if (addr == A1) return slave_ch1;
        return 24'h000000;
    endfunction

    // ---------------- SPI slave model and bus checks ----------------
    logic        prev_sclk = 1'b0;
    logic        prev_ste = 1'b1;
    logic [31:0] mosi = '0;
    logic [23:0] resp = '0;
    int rises = 0;
    int falls = 0;
    int last_rise = 0;
    int last_ste_rise = -1;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && spi_ste === 1'b1 && spi_sclk !== 1'b0)
            fail_now("sclk_idle_low", "spi_sclk high while spi_ste high");
        if (prev_ste && !spi_ste) begin
            rises = 0;
            falls = 0;
            mosi = '0;
            ste_fall_cnt++;
            if (last_ste_rise >= 0) begin
                n_cmp++;
                assert (cyc - last_ste_rise >= int'(CS_GAP))
                else begin
                    n_err++;
                    $error("FAIL ste_gap: observed %0d expected >= %0d", cyc - last_ste_rise, CS_GAP);
                end
            end
        end
        if (!spi_ste) begin
            if (!prev_sclk && spi_sclk) begin
                mosi = {mosi[30:0], spi_simo};
                if (rises > 0) chk("sclk_period", 64'(cyc - last_rise), 64'(2 * CLK_DIV));
                last_rise = cyc;
                rises++;
            end
            if (prev_sclk && !spi_sclk) begin
                falls++;
                if (falls == 8) resp = lookup(mosi[7:0]);
                if (falls >= 8 && falls <= 31) spi_somi = resp[31 - falls];
            end
        end
        if (!prev_ste && spi_ste) begin
            last_ste_rise = cyc;
            spi_somi = 1'b0;
            if (rises == 32) begin
                frame_cnt++;
                if (exp_frames.size() == 0) fail_now("simo_frame", "unexpected frame");
                else chk("simo_frame", 64'(mosi), 64'(exp_frames.pop_front()));
            end
        end
        prev_sclk = spi_sclk;
        prev_ste = spi_ste;
    end

    // ---------------- output scoreboard ----------------
    always @(negedge clk) begin
        if (overrun === 1'b1) ovr_cnt++;
        if (data_rdy === 1'b1) begin
            rdy_cnt++;
            $display("txn %0d: data_out=%h at cycle %0d", rdy_cnt, data_out, cyc);
            if (exp_data.size() == 0) fail_now("data_out", "unexpected data_rdy");
            else chk("data_out", 64'(data_out), 64'(exp_data.pop_front()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_txn();
        exp_frames.push_back({8'h00, 24'h000001});
        exp_frames.push_back({A0, 24'h000000});
        exp_frames.push_back({A1, 24'h000000});
        exp_data.push_back({fmt(slave_ch1), fmt(slave_ch0)});
    endtask

    // Raise adc_rdy and wait for busy; returns 1 when busy was seen.
    task automatic raise_and_wait_busy(output bit ok);
        int c;
        @(negedge clk);
        adc_rdy = 1'b1;
        c = 0;
        while (busy !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        adc_rdy = 1'b0;
        ok = (busy === 1'b1);
        if (!ok) fail_now("busy_rise", "busy not seen within 20 cycles");
    endtask

    task automatic wait_rdy(input bit check_lat);
        int c;
        c = 0;
        while (data_rdy !== 1'b1 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        if (data_rdy !== 1'b1) fail_now("data_rdy_timeout", "no data_rdy within 5000 cycles");
        else if (check_lat) begin
            n_cmp++;
            assert (c >= LAT - 1 && c <= LAT + 1)
            else begin
                n_err++;
                $error("FAIL latency: observed %0d expected %0d +/-1", c, LAT);
            end
        end
    endtask

    task automatic run_txn();
        bit ok;
        push_txn();
        raise_and_wait_busy(ok);
        if (ok) wait_rdy(1'b1);
        @(negedge clk);
        chk("busy_after", 64'(busy), 64'(0));
    endtask

    task automatic wait_ste_falls(input int target);
        int c;
        c = 0;
        while (ste_fall_cnt < target && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (ste_fall_cnt < target) fail_now("ste_fall_wait", "frame start not seen");
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rdy0;
        int ovr0;
        int ste0;
        bit ok;

        rst_n = 1'b0;
        start = 1'b1;
        adc_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sclk", 64'(spi_sclk), 64'(0));
        chk("rst_ste", 64'(spi_ste), 64'(1));
        chk("rst_simo", 64'(spi_simo), 64'(0));
        chk("rst_data_out", 64'(data_out), 64'(0));
        chk("rst_data_rdy", 64'(data_rdy), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_overrun", 64'(overrun), 64'(0));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic transaction: frames, data, latency.
        rdy0 = rdy_cnt;
        ovr0 = ovr_cnt;
        run_txn();
        repeat (10) @(negedge clk);
        chk("t1_rdy_count", 64'(rdy_cnt - rdy0), 64'(1));
        chk("t1_no_overrun", 64'(ovr_cnt - ovr0), 64'(0));
        chk("t1_frames", 64'(frame_cnt), 64'(3));

        // Second edge mid-RD0 is dropped with one overrun pulse.
        rdy0 = rdy_cnt;
        ovr0 = ovr_cnt;
        ste0 = ste_fall_cnt;
        push_txn();
        raise_and_wait_busy(ok);
        wait_ste_falls(ste0 + 2);
        repeat (10) @(negedge clk);
        adc_rdy = 1'b1;
        repeat (3) @(negedge clk);
        adc_rdy = 1'b0;
        wait_rdy(1'b0);
        repeat (60) @(negedge clk);
        chk("t2_overrun_count", 64'(ovr_cnt - ovr0), 64'(1));
        chk("t2_rdy_count", 64'(rdy_cnt - rdy0), 64'(1));
        chk("t2_busy_idle", 64'(busy), 64'(0));
        chk("t2_data_held", 64'(data_out), 64'({slave_ch1, slave_ch0}));

        // start=0: edges are ignored silently.
        start = 1'b0;
        ovr0 = ovr_cnt;
        ste0 = ste_fall_cnt;
        for (int i = 0; i < 3; i++) begin
            adc_rdy = 1'b1;
            repeat (4) @(negedge clk);
            adc_rdy = 1'b0;
            repeat (10) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("t3_no_frames", 64'(ste_fall_cnt - ste0), 64'(0));
        chk("t3_no_overrun", 64'(ovr_cnt - ovr0), 64'(0));
        chk("t3_busy", 64'(busy), 64'(0));
        start = 1'b1;
        run_txn();

        // Reset mid-RD1 aborts immediately; the next edge runs cleanly.
        ste0 = ste_fall_cnt;
        rdy0 = rdy_cnt;
        push_txn();
        raise_and_wait_busy(ok);
        wait_ste_falls(ste0 + 3);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_ste", 64'(spi_ste), 64'(1));
        chk("t4_rst_sclk", 64'(spi_sclk), 64'(0));
        chk("t4_rst_data_out", 64'(data_out), 64'(0));
        chk("t4_rst_busy", 64'(busy), 64'(0));
        exp_frames.delete();
        exp_data.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t4_no_rdy_after_abort", 64'(rdy_cnt - rdy0), 64'(0));
        chk("t4_idle_after_reset", 64'(busy), 64'(0));
        run_txn();

        // Channel formatting around bit 21.
        slave_ch0 = 24'h200000;
        slave_ch1 = 24'h0ABCDE;
        run_txn();
`ifdef AFE_SPI_SIGN_EXT_EN
        chk("t5_ch0_fmt", 64'(data_out[23:0]), 64'(24'hE00000));
`else
        chk("t5_ch0_fmt", 64'(data_out[23:0]), 64'(24'h200000));
`endif

        repeat (20) @(negedge clk);
        chk("end_frames_drained", 64'(exp_frames.size()), 64'(0));
        chk("end_data_drained", 64'(exp_data.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
